mips_multicycle_core: RTL and testbench
=======================================

// Module: mips_multicycle_core
// PURPOSE
//  Multi-cycle successor to the single-cycle MIPS top. Executes the same subset
//  (add, addi, lw, sw, sll, and, andi, nor, beq, jal, jr, slt) over one shared
//  instruction/data memory port with a req/ack handshake, so wait-state memories
//  are supported. Adds a configurable reset PC, an illegal-instruction halt,
//  a retire strobe and a debug register-read port.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset
//  ADDR_W        32             width of mem_addr (low ADDR_W bits of byte address)
//  ILLEGAL_HALT  1              1: unknown opcode/funct or misaligned lw/sw -> HALT; 0: treat as NOP
// PORTS
//  clock      in   1       rising-edge clock
//  reset_n    in   1       asynchronous active-low reset
//  mem_req    out  1       memory request; held until accepted
//  mem_we     out  1       1 = write (sw), 0 = read (fetch, lw)
//  mem_addr   out  ADDR_W  byte address, word aligned
//  mem_wdata  out  32      store data
//  mem_rdata  in   32      read data, valid in the cycle mem_req && mem_ack
//  mem_ack    in   1       transfer completes in any cycle with mem_req && mem_ack
//  retire     out  1       1-cycle pulse when an instruction completes
//  halted     out  1       core is in HALT
//  pc_out     out  32      current PC register
//  dbg_addr   in   5       debug register index
//  dbg_data   out  32      combinational read of register dbg_addr ($0 reads 0)
// BEHAVIOUR
//  Reset (async): state=FETCH, PC=RESET_PC, IR=0, regs=0, mem_req=0, mem_we=0,
//   mem_addr=0, mem_wdata=0, retire=0, halted=0. Reset mid-transaction drops mem_req at once.
//  States: FETCH, DECODE, EXEC, MEM, WB, HALT.
//  FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ack: IR<=mem_rdata, PC<=PC+4 -> DECODE.
//  DECODE: A<=R[rs], B<=R[rt], T<=PC+(sext(imm)<<2); illegal -> HALT (ILLEGAL_HALT=1)
//   or retire, -> FETCH.
//  EXEC: R-type/addi/andi: Y<=ALU result -> WB. lw/sw: Y<=A+sext(imm) -> MEM.
//   beq: if A==B PC<=T; retire -> FETCH. jal: R[31]<=PC; PC<={PC[31:28],tgt,2'b00};
//   retire -> FETCH. jr: PC<=A; retire -> FETCH.
//  MEM: mem_req=1, mem_addr=Y, mem_we=(sw), mem_wdata=B. On ack: sw retires -> FETCH;
//   lw latches mem_rdata into Y -> WB. Misaligned Y[1:0]!=0: no request, illegal handling.
//  WB: R[rd] (R-type) or R[rt] (I-type) <= Y; retire -> FETCH.
//  mem_addr/mem_we/mem_wdata stay stable while mem_req=1 and ack=0; no new request issues
//   in the cycle after an ack unless the next state requests.
//  Latency with ack in same cycle as req: beq/jal/jr 3, R-type/addi/andi/sw 4, lw 5.
//   Each wait cycle adds 1.
//  ALU: add/addi wrap mod 2^32 (no overflow trap); slt signed, result 0/1;
//   sll = B<<shamt; nor = ~(A|B); andi zero-extends imm; addi/lw/sw/beq sign-extend.
//  Writes to $0 discarded; $0 always reads 0. Register write and read of the same index
//   in one cycle return the old value.
//  Opcodes: R=0x00 (funct add 20, and 24, nor 27, slt 2A, sll 00, jr 08), addi 08,
//   andi 0C, lw 23, sw 2B, beq 04, jal 03.
//  HALT: mem_req=0, halted=1, PC frozen; left only by reset.
//  PC wraps mod 2^32. mem_addr = low ADDR_W bits.
// TESTING
//  Zero-wait mem; addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> R3=2, retire every 4 cycles.
//  sw $3,8($0) then lw $4,8($0), ack delayed 3 cycles each -> R4=2, addr/wdata stable while waiting.
//  beq $0,$0,+2 at PC 0x10 -> PC=0x1C after 3 cycles. Not-taken beq -> PC=0x14.
//  jal 0x40 at PC 0x20 -> R31=0x24, PC=0x100. jr $31 -> PC=0x24.
//  slt with A=-1, B=1 -> 1. nor $0,$0 into $5 -> 0xFFFFFFFF. addi $0,$0,7 -> R0 stays 0.
//  Opcode 0x3F with ILLEGAL_HALT=1 -> halted=1, mem_req=0. Reset pulse during lw wait
//   -> mem_req=0 immediately, PC=RESET_PC.

Source files
------------

// File: rtl/mips_multicycle_core_if.sv
// Shared instruction/data memory port: single req/ack channel, core is master.
interface mips_multicycle_core_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core over one shared req/ack memory port.
// Bus outputs are registered from the next state so they are clean from reset.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ADDR_W       = 32,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  mips_multicycle_core_if.master  mem,
  output logic                    retire,
  output logic                    halted,
  output logic [31:0]             pc_out,
  input  logic [4:0]              dbg_addr,
  output logic [31:0]             dbg_data
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_LW = 6'h23,
                         OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_JAL = 6'h03;
  localparam logic [5:0] F_ADD = 6'h20, F_AND = 6'h24, F_NOR = 6'h27, F_SLT = 6'h2A,
                         F_SLL = 6'h00, F_JR = 6'h08;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, t_q, t_d, y_q, y_d;
  logic              req_q, req_d, we_q, we_d, retire_q, retire_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       regs_q [32];
  logic              rf_we, trap;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] tgt;
  logic [31:0] sext_imm, zext_imm, alu_r;
  logic        legal;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign tgt      = ir_q[25:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0, imm};

  always_comb begin
    if (op == OP_R)
      legal = (funct == F_ADD) || (funct == F_AND) || (funct == F_NOR) ||
              (funct == F_SLT) || (funct == F_SLL) || (funct == F_JR);
    else
      legal = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_LW) ||
              (op == OP_SW) || (op == OP_BEQ) || (op == OP_JAL);
  end

  always_comb begin
    unique case (funct)
      F_ADD:   alu_r = a_q + b_q;
      F_AND:   alu_r = a_q & b_q;
      F_NOR:   alu_r = ~(a_q | b_q);
      F_SLT:   alu_r = {31'h0, $signed(a_q) < $signed(b_q)};
      F_SLL:   alu_r = b_q << shamt;
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    t_d      = t_q;
    y_d      = y_q;
    retire_d = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = '0;
    trap     = 1'b0;
    case (state_q)
      S_FETCH: if (req_q && mem.mem_ack) begin
        ir_d    = mem.mem_rdata;
        pc_d    = pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d = regs_q[rs];
        b_d = regs_q[rt];
        t_d = pc_q + (sext_imm << 2);
        if (legal) state_d = S_EXEC;
        else       trap    = 1'b1;
      end
      S_EXEC: begin
        case (op)
          OP_R: if (funct == F_JR) begin
            pc_d = a_q; retire_d = 1'b1; state_d = S_FETCH;
          end else begin
            y_d = alu_r; state_d = S_WB;
          end
          OP_ADDI: begin y_d = a_q + sext_imm; state_d = S_WB; end
          OP_ANDI: begin y_d = a_q & zext_imm; state_d = S_WB; end
          OP_LW, OP_SW: begin y_d = a_q + sext_imm; state_d = S_MEM; end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = t_q;
            retire_d = 1'b1; state_d = S_FETCH;
          end
          OP_JAL: begin
            rf_we = 1'b1; rf_waddr = 5'd31; rf_wdata = pc_q;
            pc_d = {pc_q[31:28], tgt, 2'b00};
            retire_d = 1'b1; state_d = S_FETCH;
          end
          default: trap = 1'b1;
        endcase
      end
      S_MEM: begin
        // Misaligned address never reached the bus; treat it like an illegal op.
        if (y_q[1:0] != 2'b00) trap = 1'b1;
        else if (req_q && mem.mem_ack) begin
          if (op == OP_SW) begin
            retire_d = 1'b1; state_d = S_FETCH;
          end else begin
            y_d = mem.mem_rdata; state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (op == OP_R) ? rd : rt;
        rf_wdata = y_q;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    if (trap) begin
      if (ILLEGAL_HALT) state_d = S_HALT;
      else begin
        retire_d = 1'b1; state_d = S_FETCH;
      end
    end
  end

  // Bus fields only move when a new transfer starts, so they hold through wait states.
  always_comb begin
    req_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_d == S_FETCH) begin
      req_d  = 1'b1;
      addr_d = pc_d[ADDR_W-1:0];
    end else if (state_d == S_MEM && y_d[1:0] == 2'b00) begin
      req_d   = 1'b1;
      we_d    = (op == OP_SW);
      addr_d  = y_d[ADDR_W-1:0];
      wdata_d = b_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      t_q      <= '0;
      y_q      <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      retire_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      t_q      <= t_d;
      y_q      <= y_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      retire_q <= retire_d;
      if (rf_we && rf_waddr != 5'd0) regs_q[rf_waddr] <= rf_wdata;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign retire        = retire_q;
  assign halted        = (state_q == S_HALT);
  assign pc_out        = pc_q;
  assign dbg_data      = (dbg_addr == 5'd0) ? 32'h0 : regs_q[dbg_addr];
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench: programs push expected retire results, a monitor checks each retire.
module tb_mips_multicycle_core;
  logic        clock, reset_n, retire, halted;
  logic [31:0] pc_out, dbg_data;
  logic [4:0]  dbg_addr;

  mips_multicycle_core_if #(.ADDR_W(32)) bus ();

  mips_multicycle_core #(.RESET_PC(32'h0), .ADDR_W(32), .ILLEGAL_HALT(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .mem(bus), .retire(retire), .halted(halted),
    .pc_out(pc_out), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  ridx;
    logic [31:0] rval;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [256];
  int          checks = 0, errors = 0, cyc = 0, acks = 0, data_waits = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  initial forever @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd,
                                       input int sh, input logic [5:0] fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt,
                                       input logic [15:0] imm);
    return {op, rs[4:0], rt[4:0], imm};
  endfunction

  task automatic push(input logic [31:0] pc, input int ridx, input logic [31:0] rval,
                      input int lat);
    exp_t e;
    e.pc = pc; e.ridx = ridx[4:0]; e.rval = rval; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'hFC00_0000;
  endtask

  // Memory slave: fetches (below 0x200) are zero-wait, data accesses take data_waits.
  initial begin
    int          wcnt;
    int          w;
    logic [31:0] c_addr, c_wdata;
    logic        c_we;
    wcnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end else begin
        if (bus.mem_ack) wcnt = 0;
        bus.mem_ack = 1'b0;
        if (bus.mem_req) begin
          w = (bus.mem_addr >= 32'h200) ? data_waits : 0;
          if (wcnt == 0) begin
            c_addr = bus.mem_addr; c_we = bus.mem_we; c_wdata = bus.mem_wdata;
          end else begin
            chk("hold_addr", bus.mem_addr, c_addr);
            chk("hold_we", {31'h0, bus.mem_we}, {31'h0, c_we});
            chk("hold_wdata", bus.mem_wdata, c_wdata);
          end
          if (wcnt >= w) begin
            bus.mem_ack = 1'b1;
            acks++;
            if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
            else bus.mem_rdata = mem[bus.mem_addr[9:2]];
          end else wcnt++;
        end
      end
    end
  end

  // Retire monitor: pops one expectation per retire pulse.
  initial begin
    exp_t e;
    int   last;
    last = 0;
    dbg_addr = 5'd0;
    forever begin
      @(negedge clock);
      if (reset_n && retire) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_retire actual pc=%h expected none", pc_out);
        end else begin
          e = sb.pop_front();
          dbg_addr = e.ridx;
          #1;
          chk("retire_pc", pc_out, e.pc);
          chk("retire_reg", dbg_data, e.rval);
          if (e.lat != 0) chk("retire_latency", cyc - last, e.lat);
        end
        last = cyc;
      end
    end
  end

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clock);
    chk("halt_reached", {31'h0, halted}, 32'h1);
  endtask

  initial begin
    logic found;
    int   a0;
    reset_n = 1'b0;
    clear_mem();
    // Program A: ALU, branches, jal/jr, $0 write, then illegal opcode.
    mem[0]  = i_op(6'h08, 0, 1, 16'd5);          push(32'h04, 1, 32'd5, 0);
    mem[1]  = i_op(6'h08, 0, 2, 16'hFFFD);       push(32'h08, 2, 32'hFFFF_FFFD, 4);
    mem[2]  = r_op(1, 2, 3, 0, 6'h20);           push(32'h0C, 3, 32'd2, 4);
    mem[3]  = r_op(0, 0, 5, 0, 6'h27);           push(32'h10, 5, 32'hFFFF_FFFF, 4);
    mem[4]  = i_op(6'h04, 0, 0, 16'd2);          push(32'h1C, 0, 32'd0, 3);
    mem[7]  = r_op(5, 1, 6, 0, 6'h2A);           push(32'h20, 6, 32'd1, 4);
    mem[8]  = {6'h03, 26'h40};                   push(32'h100, 31, 32'h24, 3);
    mem[64] = i_op(6'h04, 1, 2, 16'd5);          push(32'h104, 1, 32'd5, 3);
    mem[65] = i_op(6'h08, 0, 0, 16'd7);          push(32'h108, 0, 32'd0, 4);
    mem[66] = r_op(0, 1, 9, 4, 6'h00);           push(32'h10C, 9, 32'h50, 4);
    mem[67] = i_op(6'h0C, 2, 10, 16'hFFF0);      push(32'h110, 10, 32'h0000_FFF0, 4);
    mem[68] = r_op(3, 5, 11, 0, 6'h24);          push(32'h114, 11, 32'd2, 4);
    mem[69] = r_op(31, 0, 0, 0, 6'h08);          push(32'h24, 31, 32'h24, 3);
    repeat (2) @(negedge clock);
    chk("rst_req", {31'h0, bus.mem_req}, 32'h0);
    chk("rst_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_retire", {31'h0, retire}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    reset_n = 1'b1;
    wait_halt(600);
    chk("haltA_req", {31'h0, bus.mem_req}, 32'h0);
    chk("haltA_pc", pc_out, 32'h28);
    chk("A_pending", sb.size(), 32'h0);
    repeat (3) @(negedge clock);
    chk("haltA_pc_frozen", pc_out, 32'h28);
    chk("haltA_req_frozen", {31'h0, bus.mem_req}, 32'h0);

    // Program B: store/load with 3 wait states, then reset during a load wait.
    reset_n = 1'b0;
    clear_mem();
    data_waits = 3;
    mem[0] = i_op(6'h08, 0, 3, 16'd2);           push(32'h04, 3, 32'd2, 0);
    mem[1] = i_op(6'h2B, 0, 3, 16'h0208);        push(32'h08, 3, 32'd2, 7);
    mem[2] = i_op(6'h23, 0, 4, 16'h0208);        push(32'h0C, 4, 32'd2, 8);
    mem[3] = i_op(6'h23, 0, 12, 16'h0208);
    @(negedge clock);
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clock);
      found = bus.mem_req && !bus.mem_we && bus.mem_addr == 32'h208 && pc_out == 32'h10;
    end
    chk("lw_wait_seen", {31'h0, found}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_req", {31'h0, bus.mem_req}, 32'h0);
    chk("midrst_pc", pc_out, 32'h0);
    chk("midrst_halted", {31'h0, halted}, 32'h0);
    chk("sw_mem", mem[130], 32'd2);
    chk("B_pending", sb.size(), 32'h0);

    // Program C: misaligned lw halts without a data request.
    clear_mem();
    data_waits = 0;
    mem[0] = i_op(6'h23, 0, 1, 16'h0002);
    a0 = acks;
    @(negedge clock);
    reset_n = 1'b1;
    wait_halt(60);
    chk("misal_pc", pc_out, 32'h4);
    chk("misal_acks", acks - a0, 32'd1);
    chk("misal_req", {31'h0, bus.mem_req}, 32'h0);
    repeat (2) @(negedge clock);
    chk("C_pending", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
